// File: rtl/johnson_pkg.sv
// Purpose : shared types and Johnson-code helpers for the phase monitor.
// Latency : n/a (package: types, constants, pure functions).
// Backpr. : n/a.
//
// Helpers operate on a vector of up to JC_MAX_W bits plus a run-time width
// so that one function serves every WIDTH the monitor is built with. Loops
// run over the fixed maximum and gate on the width, so they unroll cleanly
// when the width is an elaboration constant.
package johnson_pkg;

   typedef enum logic [1:0] {
      ST_ACQ    = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCK   = 2'd2
   } jc_state_t;

   localparam int ERR_CNT_MAX = 255;
   localparam int JC_MAX_W    = 32;

   typedef logic [JC_MAX_W-1:0] jc_vec_t;

   // Successor in the shift-left direction: {q[w-2:0], ~q[w-1]}.
   function automatic jc_vec_t jc_next(input jc_vec_t q, input int width);
      jc_vec_t r;
      r = '0;
      for (int i = 1; i < JC_MAX_W; i++) begin
         if (i < width) r[i] = q[i-1];
      end
      for (int i = 0; i < JC_MAX_W; i++) begin
         if (i == width - 1) r[0] = ~q[i];
      end
      return r;
   endfunction

   // A Johnson code has at most one boundary between a run of ones and a
   // run of zeros, i.e. at most one adjacent-bit difference.
   function automatic logic jc_legal(input jc_vec_t q, input int width);
      int n;
      n = 0;
      for (int i = 0; i < JC_MAX_W - 1; i++) begin
         if ((i < width - 1) && (q[i] != q[i+1])) n++;
      end
      return (n <= 1);
   endfunction

   // Phase: ones filling from bit 0 count up; ones draining from bit 0
   // count the second half of the revolution.
   function automatic int jc_idx(input jc_vec_t q, input int width);
      int pc;
      pc = 0;
      for (int i = 0; i < JC_MAX_W; i++) begin
         if ((i < width) && q[i]) pc++;
      end
      if (q[0]) return pc;
      return (2 * width - pc) % (2 * width);
   endfunction

endpackage

// File: rtl/johnson_decode.sv
// Purpose : combinational decode of a Johnson code into legal flag, binary
//           phase index and one-hot phase.
// Latency : 0 cycles (purely combinational). Backpr.: none.
//
// Ports:
//   i_q      [WIDTH-1:0] Johnson code to decode
//   o_legal              code is a member of the 2*WIDTH Johnson sequence
//   o_idx    [IDX_W-1:0] phase index (meaningful only when o_legal)
//   o_onehot [NPH-1:0]   one-hot phase, all zero when the code is illegal
module johnson_decode
   import johnson_pkg::*;
#(
   parameter  int WIDTH = 4,
   localparam int NPH   = 2 * WIDTH,
   localparam int IDX_W = $clog2(NPH)
) (
   input  logic [WIDTH-1:0] i_q,
   output logic             o_legal,
   output logic [IDX_W-1:0] o_idx,
   output logic [NPH-1:0]   o_onehot
);

   localparam logic [NPH-1:0] ONE = {{(NPH-1){1'b0}}, 1'b1};

   always_comb begin
      o_legal  = jc_legal(JC_MAX_W'(i_q), WIDTH);
      o_idx    = '0;
      // Map the integer phase onto the narrow index without keeping an
      // intermediate 32-bit signal around.
      for (int k = 0; k < NPH; k++) begin
         if (jc_idx(JC_MAX_W'(i_q), WIDTH) == k) o_idx = IDX_W'(k);
      end
      o_onehot = o_legal ? (ONE << o_idx) : '0;
   end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Purpose : samples a Johnson counter every clock, decodes its phase and
//           tracks lock to the legal sequence with error/revolution counts.
// Latency : 1 cycle; outputs after edge t reflect q_in sampled at edge t.
// Backpr. : none; q_in is sampled unconditionally every edge.
//
// Ports:
//   Clk, Reset (async, active-high)
//   q_in         [WIDTH-1:0]  Johnson counter output
//   phase_idx    [IDX_W-1:0]  phase of last legal sample
//   phase_onehot [2*WIDTH-1:0] one-hot phase, zero after an illegal sample
//   locked                     sequence tracking established
//   illegal                    last sample was not a Johnson code
//   err                        one-cycle pulse on a sequence error while locked
//   err_cnt      [7:0]         saturating count of err pulses
//   rev_count    [CYC_W-1:0]   wrapping count of revolutions completed in lock
module johnson_phase_monitor
   import johnson_pkg::*;
#(
   parameter  int WIDTH  = 4,
   parameter  int LOCK_N = 2,
   parameter  int CYC_W  = 8,
   localparam int NPH    = 2 * WIDTH,
   localparam int IDX_W  = $clog2(NPH),
   localparam int MC_W   = $clog2(LOCK_N + 1)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [WIDTH-1:0] q_in,
   output logic [IDX_W-1:0] phase_idx,
   output logic [NPH-1:0]   phase_onehot,
   output logic             locked,
   output logic             illegal,
   output logic             err,
   output logic [7:0]       err_cnt,
   output logic [CYC_W-1:0] rev_count
);

   // ---------------------------------------------------------------------
   // Decode of the current sample
   // ---------------------------------------------------------------------
   logic             w_legal;
   logic [IDX_W-1:0] w_idx;
   logic [NPH-1:0]   w_onehot;

   johnson_decode #(.WIDTH(WIDTH)) u_decode (
      .i_q      (q_in),
      .o_legal  (w_legal),
      .o_idx    (w_idx),
      .o_onehot (w_onehot)
   );

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   jc_state_t        r_state;
   logic [MC_W-1:0]  r_match_cnt;
   logic [WIDTH-1:0] r_prev;
   logic [IDX_W-1:0] r_phase_idx;
   logic [NPH-1:0]   r_onehot;
   logic             r_illegal;
   logic             r_err;
   logic [7:0]       r_err_cnt;
   logic [CYC_W-1:0] r_rev;

   jc_state_t        w_state_nxt;
   logic [MC_W-1:0]  w_cnt_nxt;
   logic             w_err_nxt;
   logic [WIDTH-1:0] w_expected;
   logic             w_match;
   logic             w_rev_inc;

   // A sample is correct only if it is exactly the successor of the last
   // legal sample; a hold (sample == prev) therefore never matches.
   assign w_expected = WIDTH'(jc_next(JC_MAX_W'(r_prev), WIDTH));
   assign w_match    = w_legal && (q_in == w_expected);

   // Revolution boundary: a correct return to phase 0 while already locked.
   assign w_rev_inc  = (r_state == ST_LOCK) && w_match && (w_idx == '0);

   // ---------------------------------------------------------------------
   // Next-state / pulse logic
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_match_cnt;
      w_err_nxt   = 1'b0;

      case (r_state)
         ST_ACQ: begin
            if (w_legal) begin
               w_state_nxt = ST_VERIFY;
               w_cnt_nxt   = '0;
            end
         end

         ST_VERIFY: begin
            if (!w_legal) begin
               w_state_nxt = ST_ACQ;
               w_cnt_nxt   = '0;
            end else if (w_match) begin
               // Promote on the LOCK_N-th consecutive correct transition.
               if (r_match_cnt == MC_W'(LOCK_N - 1)) begin
                  w_state_nxt = ST_LOCK;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt   = r_match_cnt + 1'b1;
               end
            end else begin
               w_cnt_nxt = '0;
            end
         end

         ST_LOCK: begin
            if (!w_match) begin
               w_err_nxt   = 1'b1;
               w_cnt_nxt   = '0;
               // A legal but wrong code is still a usable reference, so
               // re-verify from it; an illegal code forces reacquisition.
               w_state_nxt = w_legal ? ST_VERIFY : ST_ACQ;
            end
         end

         default: begin
            w_state_nxt = ST_ACQ;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state     <= ST_ACQ;
         r_match_cnt <= '0;
         r_prev      <= '0;
         r_phase_idx <= '0;
         r_onehot    <= '0;
         r_illegal   <= 1'b0;
         r_err       <= 1'b0;
         r_err_cnt   <= '0;
         r_rev       <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_match_cnt <= w_cnt_nxt;
         r_err       <= w_err_nxt;
         r_illegal   <= ~w_legal;
         // Decoder already zeroes the one-hot for illegal codes.
         r_onehot    <= w_onehot;

         // Illegal samples leave the phase reference untouched.
         if (w_legal) begin
            r_prev      <= q_in;
            r_phase_idx <= w_idx;
         end

         if (w_err_nxt && (r_err_cnt != 8'(ERR_CNT_MAX))) begin
            r_err_cnt <= r_err_cnt + 8'd1;
         end

         if (w_rev_inc) begin
            r_rev <= r_rev + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign phase_idx    = r_phase_idx;
   assign phase_onehot = r_onehot;
   assign locked       = (r_state == ST_LOCK);
   assign illegal      = r_illegal;
   assign err          = r_err;
   assign err_cnt      = r_err_cnt;
   assign rev_count    = r_rev;

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Purpose : self-checking bench for johnson_phase_monitor against a
//           table-driven phase model; randomised and directed stimulus.
// Latency : checks 2 ns after each rising edge.
// Backpr. : n/a.
module tb_johnson_phase_monitor;

   localparam int W      = 4;
   localparam int NPH    = 2 * W;
   localparam int LOCK_N = 2;

   logic       Clk   = 1'b0;
   logic       Reset = 1'b0;
   logic [3:0] q_in  = 4'b0000;

   logic [2:0] phase_idx,    phase_idx2;
   logic [7:0] phase_onehot, phase_onehot2;
   logic       locked,  locked2;
   logic       illegal, illegal2;
   logic       err,     err2;
   logic [7:0] err_cnt, err_cnt2;
   logic [7:0] rev_count;
   logic [1:0] rev_count2;

   always #5 Clk = ~Clk;

   johnson_phase_monitor #(.WIDTH(W), .LOCK_N(LOCK_N), .CYC_W(8)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .q_in         (q_in),
      .phase_idx    (phase_idx),
      .phase_onehot (phase_onehot),
      .locked       (locked),
      .illegal      (illegal),
      .err          (err),
      .err_cnt      (err_cnt),
      .rev_count    (rev_count)
   );

   // Narrow revolution counter to observe wrap-around.
   johnson_phase_monitor #(.WIDTH(W), .LOCK_N(LOCK_N), .CYC_W(2)) dut2 (
      .Clk          (Clk),
      .Reset        (Reset),
      .q_in         (q_in),
      .phase_idx    (phase_idx2),
      .phase_onehot (phase_onehot2),
      .locked       (locked2),
      .illegal      (illegal2),
      .err          (err2),
      .err_cnt      (err_cnt2),
      .rev_count    (rev_count2)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got=%0h exp=%0h", tag, $time, got, exp);
      end
   endtask

   // ---------------------------------------------------------------------
   // Reference model: phases are integers 0..NPH-1, codes come from a table.
   // ---------------------------------------------------------------------
   function automatic logic [3:0] code_of(input int k);
      int v;
      if (k <= W) v = (1 << k) - 1;
      else        v = 15 & ~((1 << (k - W)) - 1);
      return v[3:0];
   endfunction

   function automatic int idx_of(input logic [3:0] q);
      for (int k = 0; k < NPH; k++) begin
         if (code_of(k) == q) return k;
      end
      return -1;
   endfunction

   int  m_prev, m_streak, m_idx, m_errcnt, m_rev;
   int  m_onehot;
   bit  m_locked, m_verify, m_illegal, m_err;

   task automatic model_reset();
      m_prev = 0; m_streak = 0; m_idx = 0; m_errcnt = 0; m_rev = 0;
      m_onehot = 0; m_locked = 0; m_verify = 0; m_illegal = 0; m_err = 0;
   endtask

   task automatic model_step(input logic [3:0] q);
      int k;
      bit legal, good;
      k     = idx_of(q);
      legal = (k >= 0);
      good  = legal && (k == (m_prev + 1) % NPH);
      m_err = 0;
      if (m_locked) begin
         if (good) begin
            if (k == 0) m_rev++;
         end else begin
            m_err = 1;
            if (m_errcnt < 255) m_errcnt++;
            m_locked = 0;
            m_verify = legal;
            m_streak = 0;
         end
      end else if (m_verify) begin
         if (!legal) m_verify = 0;
         else if (good) begin
            m_streak++;
            if (m_streak == LOCK_N) begin
               m_locked = 1;
               m_verify = 0;
            end
         end else m_streak = 0;
      end else if (legal) begin
         m_verify = 1;
         m_streak = 0;
      end
      if (legal) begin
         m_prev = k; m_idx = k; m_illegal = 0; m_onehot = 1 << k;
      end else begin
         m_illegal = 1; m_onehot = 0;
      end
   endtask

   task automatic check_all();
      chk("phase_idx",    32'(phase_idx),    32'(m_idx));
      chk("phase_onehot", 32'(phase_onehot), 32'(m_onehot));
      chk("locked",       32'(locked),       32'(m_locked));
      chk("illegal",      32'(illegal),      32'(m_illegal));
      chk("err",          32'(err),          32'(m_err));
      chk("err_cnt",      32'(err_cnt),      32'(m_errcnt));
      chk("rev_count",    32'(rev_count),    32'(m_rev % 256));
      chk("rev_count_w2", 32'(rev_count2),   32'(m_rev % 4));
   endtask

   // One clock: present a code, let the edge take it, then compare.
   task automatic cycle(input logic [3:0] code);
      q_in = code;
      @(posedge Clk);
      model_step(code);
      #2;
      check_all();
   endtask

   int c = 0;  // phase the healthy counter is presenting

   task automatic run_ok(input int n);
      for (int i = 0; i < n; i++) begin
         cycle(code_of(c));
         c = (c + 1) % NPH;
      end
   endtask

   logic [3:0] ill_codes[$];

   initial begin
      for (int v = 0; v < 16; v++) begin
         logic [3:0] cv;
         cv = v[3:0];
         if (idx_of(cv) < 0) ill_codes.push_back(cv);
      end

      // Reset, released at 6 ns together with the counter.
      #1 Reset = 1'b1;
      model_reset();
      #3 check_all();
      #2 Reset = 1'b0;

      // Startup lock: 0000, 0001, 0011 on edges 1..3.
      run_ok(2);
      chk("not_locked_edge2", 32'(locked), 32'd0);
      run_ok(1);
      chk("locked_edge3", 32'(locked), 32'd1);

      // Revolutions.
      run_ok(5);
      run_ok(16);
      chk("rev_after_16", 32'(rev_count), 32'd2);
      run_ok(24);
      chk("rev_wrap_w2", 32'(rev_count2), 32'd1);

      // Illegal injection while locked (counter keeps running).
      cycle(4'b0101);
      c = (c + 1) % NPH;
      chk("inj_err",     32'(err),          32'd1);
      chk("inj_illegal", 32'(illegal),      32'd1);
      chk("inj_onehot",  32'(phase_onehot), 32'd0);
      chk("inj_errcnt",  32'(err_cnt),      32'd1);
      run_ok(LOCK_N);
      chk("inj_not_yet", 32'(locked), 32'd0);
      run_ok(1);
      chk("inj_relock",  32'(locked), 32'd1);

      // Legal skip 0011 -> 1111 while locked.
      for (int i = 0; i < NPH && c != 3; i++) run_ok(1);
      chk("skip_pre_locked", 32'(locked), 32'd1);
      cycle(code_of(4));
      c = 5;
      chk("skip_err",     32'(err),       32'd1);
      chk("skip_illegal", 32'(illegal),   32'd0);
      chk("skip_idx",     32'(phase_idx), 32'd4);
      run_ok(1);
      chk("skip_verify",  32'(locked),    32'd0);
      run_ok(1);
      chk("skip_relock",  32'(locked),    32'd1);

      // Randomised traffic: mostly healthy, with holds, skips and garbage.
      for (int i = 0; i < 400; i++) begin
         int r;
         r = $urandom_range(0, 19);
         if (r == 0) begin
            cycle(ill_codes[$urandom_range(0, ill_codes.size() - 1)]);
         end else if (r == 1) begin
            cycle(code_of((c + NPH - 1) % NPH));
         end else if (r == 2) begin
            c = (c + $urandom_range(1, NPH - 2)) % NPH;
            run_ok(1);
         end else begin
            run_ok(1);
         end
      end

      // Reset mid-lock for 11 ns; clears asynchronously.
      run_ok(10);
      chk("pre_reset_locked", 32'(locked), 32'd1);
      Reset = 1'b1;
      model_reset();
      #1;
      check_all();
      chk("reset_errcnt", 32'(err_cnt), 32'd0);
      #10 Reset = 1'b0;
      c = 0;
      run_ok(3);
      chk("reset_relock", 32'(locked), 32'd1);

      // Saturation: 300 lock/error rounds.
      for (int i = 0; i < 300; i++) begin
         cycle(4'b0101);
         c = (c + 1) % NPH;
         run_ok(LOCK_N + 1);
      end
      chk("err_cnt_sat", 32'(err_cnt), 32'd255);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1);
   end

endmodule

// File: doc/johnson_phase_monitor.md
# johnson_phase_monitor

Downstream consumer of the 4-bit Johnson counter. Samples the counter's `Q` bus every clock and decodes it into a binary phase index and a one-hot phase. It checks every transition against the legal Johnson sequence, with lock/acquire tracking, error counting and revolution counting. It feeds phase-sequenced logic and lets the verification benches assert counter health.

## Interface
- `WIDTH`, 4: Johnson register width; the sequence has 2·WIDTH states. Must be ≥2.
- `LOCK_N`, 2: consecutive correct transitions required to lock. Must be ≥1.
- `CYC_W`, 8: width of the revolution counter.
- `Clk` in 1: clock. All state updates on the rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `q_in` in WIDTH: Johnson counter output, sampled every edge.
- `phase_idx` out clog2(2·WIDTH): decoded phase of the last legal sample.
- `phase_onehot` out 2·WIDTH: one-hot phase. All zero when the last sample was illegal.
- `locked` out 1: sequence tracking established.
- `illegal` out 1: last sample was not a Johnson code.
- `err` out 1: one-cycle pulse on a sequence error while locked.
- `err_cnt` out 8: count of `err` pulses; saturates at 255.
- `rev_count` out CYC_W: completed revolutions while locked; wraps modulo 2^CYC_W.

## Operation
- **Sequence direction:** `next(q) = {q[WIDTH-2:0], ~q[WIDTH-1]}`. For WIDTH=4: 0000→0001→0011→0111→1111→1110→1100→1000→0000.
- **Legal code:** at most one adjacent-bit difference across `q`.
- **Phase index:** `idx = q[0] ? popcount(q) : (2·WIDTH − popcount(q)) mod 2·WIDTH`. Examples: 0000→0, 0111→3, 1110→5, 1000→7.
- **Internal `prev` register:** holds the last legal sample. `expected = next(prev)`.
- **FSM states:** ACQ (reset state), VERIFY, LOCK. `match_cnt` counts 0..LOCK_N.
- **ACQ:**
  - Legal sample → VERIFY, `match_cnt`=0.
  - Illegal sample → stay in ACQ.
- **VERIFY:**
  - Sample == expected → `match_cnt`+1. On reaching LOCK_N → LOCK.
  - Legal sample ≠ expected → stay in VERIFY, `match_cnt`=0.
  - Illegal sample → ACQ.
  - No `err` in this state.
- **LOCK:**
  - Sample == expected → stay in LOCK.
  - Legal mismatch → `err` pulse, `err_cnt`+1, go to VERIFY with `match_cnt`=0.
  - Illegal sample → `err` pulse, `err_cnt`+1, go to ACQ.
  - Hold (sample == prev) counts as a mismatch.
- **`rev_count`:** increments on an edge where the state was LOCK before the edge, the sample is correct, and its idx == 0.
- **Legal samples:** update `prev`, `phase_idx` and `phase_onehot`, and clear `illegal`.
- **Illegal samples:** set `illegal`, zero `phase_onehot`, and hold `phase_idx` and `prev`.

## Timing
- **Latency:** all outputs are registered with 1-cycle latency. Outputs after edge t reflect the `q_in` present just before edge t.
- **Reset values:** while `Reset`=1, `phase_idx`=0, `phase_onehot`=0, `locked`=0, `illegal`=0, `err`=0, `err_cnt`=0, `rev_count`=0, `prev`=0, state=ACQ.
- **`locked`:** rises after the edge that takes the LOCK_N-th consecutive correct sample. It falls after the edge that detects the error, on the same edge as `err` rises.
- **`err`:** high for exactly one cycle per error. Back-to-back errors give back-to-back pulses only when each occurs in LOCK. The second bad sample normally lands in ACQ/VERIFY and produces no pulse.
- **Reset mid-operation:** all state clears immediately and asynchronously. The first post-reset edge behaves as in ACQ.
- **Startup with a shared reset and LOCK_N=2:** the monitor samples 0000, 0001, 0011 on edges 1-3, and `locked`=1 after edge 3.

## Structure
- **Package `johnson_pkg`:**
  - FSM state enum (ACQ, VERIFY, LOCK).
  - Functions `jc_next`, `jc_legal`, `jc_idx`, parameterised on WIDTH.
  - Constant `ERR_CNT_MAX`=255.
- **Sub-module `johnson_decode`:** purely combinational; `q` → legal, idx, one-hot. Instantiated once on `q_in`. The top module holds the FSM, registers and counters.

## Test plan
- **Lock and decode:** shared Reset with the Johnson counter, release at 6 ns.
  - `locked`=1 after the 3rd edge.
  - `phase_idx` follows 0,1,2,…,7,0.
  - `phase_onehot` = `1<<phase_idx`.
  - `err` never asserts.
- **Revolutions:** 16 further locked cycles → `rev_count`=2. With CYC_W=2, 5 revolutions → `rev_count`=1 (wraps).
- **Illegal injection:** force `q_in`=0101 for one cycle while locked.
  - That edge: `err` pulse, `illegal`=1, `phase_onehot`=0, `locked`=0, `err_cnt`=1.
  - Then legal codes resume and `locked` returns after LOCK_N+1 edges.
- **Legal skip:** 0011 → 1111 while locked.
  - `err`=1, `illegal`=0, `phase_idx`=4, state VERIFY.
  - Relock after 2 correct transitions.
- **Reset mid-lock:** assert Reset for 11 ns mid-run. All outputs are zero asynchronously, `err_cnt` holds 0, and lock is reacquired after release.
- **Saturation:** 300 forced lock/error cycles → `err_cnt` stays at 255.
